framebuffer_scanout_arbiter: RTL and testbench

Sequences framebuffer reads that keep the pixel line FIFO fed ahead of the 640x480 timing generator. Shares the single framebuffer memory port between display scanout bursts and a GPU requester. Display traffic gets strict priority when the FIFO is low; otherwise the two requesters alternate round-robin. Sits between the display timing generator (frame, de), the pixel FIFO (level, flush) and the memory controller.

---
 rtl/graphite_display_pkg.sv | 30 +++
 rtl/framebuffer_scanout_arbiter_rr.sv | 48 ++++
 rtl/framebuffer_scanout_arbiter.sv | 177 +++++++++++++++++
 tb/tb_framebuffer_scanout_arbiter.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/graphite_display_pkg.sv
`default_nettype none
// ============================================================================
// Package     : graphite_display_pkg
// Description : Shared types and helpers for the framebuffer scanout path:
//               arbiter FSM state encoding, requester identifiers and the
//               bursts-per-frame calculation.
// Revision    : 1.0 - initial release
// ============================================================================
package graphite_display_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_ISSUE_D = 3'd1,
        ST_WAIT_D  = 3'd2,
        ST_ISSUE_G = 3'd3,
        ST_WAIT_G  = 3'd4
    } scanout_state_t;

    typedef enum logic {
        REQ_DISP = 1'b0,
        REQ_GPU  = 1'b1
    } requester_t;

    // Number of scanout bursts needed to fetch one full active frame.
    function automatic int bursts_per_frame(input int h_res, input int v_res, input int burst);
        return (h_res * v_res) / burst;
    endfunction

endpackage
`default_nettype wire

// File: rtl/framebuffer_scanout_arbiter_rr.sv
`default_nettype none
// ============================================================================
// Module      : scanout_rr_arb2
// Description : Two-requester round-robin (display vs GPU) with an urgent
//               override for the display side. Holds the last-winner
//               register; the grant itself is combinational.
// Ports       : clk_pix, rst_n        - clock, async active-low reset
//               disp_pend, gpu_req    - request lines
//               urgent                - display wins regardless of history
//               accept_disp/gpu       - winner accepted by memory (update last)
//               grant_valid           - some requester wins this cycle
//               grant_sel             - which requester wins
// Revision    : 1.0 - initial release
// ============================================================================
module scanout_rr_arb2
    import graphite_display_pkg::*;
(
    input  logic       clk_pix,
    input  logic       rst_n,
    input  logic       disp_pend,
    input  logic       gpu_req,
    input  logic       urgent,
    input  logic       accept_disp,
    input  logic       accept_gpu,
    output logic       grant_valid,
    output requester_t grant_sel
);

    requester_t r_last;
    logic       w_disp_win;

    // Display wins when urgent, uncontested, or when it is its turn.
    assign w_disp_win  = disp_pend && (urgent || !gpu_req || (r_last == REQ_GPU));
    assign grant_valid = disp_pend || gpu_req;
    assign grant_sel   = w_disp_win ? REQ_DISP : REQ_GPU;

    always_ff @(posedge clk_pix or negedge rst_n) begin
        if (!rst_n) begin
            r_last <= REQ_GPU;
        end else if (accept_disp) begin
            r_last <= REQ_DISP;
        end else if (accept_gpu) begin
            r_last <= REQ_GPU;
        end
    end

endmodule
`default_nettype wire

// File: rtl/framebuffer_scanout_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : framebuffer_scanout_arbiter
// Description : Shares one framebuffer memory port between display scanout
//               bursts and a GPU requester, keeping the pixel FIFO fed ahead
//               of the timing generator. One transaction outstanding.
// Ports       : clk_pix, rst_n         - clock, async active-low reset
//               enable, frame, de      - scanout enable / timing generator
//               fifo_level, fifo_flush - pixel FIFO occupancy / clear pulse
//               underflow              - sticky FIFO-empty-while-active flag
//               gpu_req/we/addr, gpu_gnt, gpu_done - GPU requester handshake
//               mem_req/we/burst/addr, mem_ready, mem_done - memory port
// Revision    : 1.0 - initial release
// ============================================================================
module framebuffer_scanout_arbiter
    import graphite_display_pkg::*;
#(
    parameter int H_RES      = 640,
    parameter int V_RES      = 480,
    parameter int ADDRW      = 24,
    parameter int BURST      = 16,
    parameter int FB_BASE    = 0,
    parameter int FIFO_DEPTH = 64,
    parameter int LOW_WATER  = 16
) (
    input  logic                          clk_pix,
    input  logic                          rst_n,
    input  logic                          enable,
    input  logic                          frame,
    input  logic                          de,
    input  logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic                          fifo_flush,
    output logic                          underflow,
    input  logic                          gpu_req,
    input  logic                          gpu_we,
    input  logic [ADDRW-1:0]              gpu_addr,
    output logic                          gpu_gnt,
    output logic                          gpu_done,
    output logic                          mem_req,
    output logic                          mem_we,
    output logic                          mem_burst,
    output logic [ADDRW-1:0]              mem_addr,
    input  logic                          mem_ready,
    input  logic                          mem_done
);

    localparam int LW      = $clog2(FIFO_DEPTH) + 1;
    localparam int C_BPF   = bursts_per_frame(H_RES, V_RES, BURST);
    localparam int CW      = $clog2(C_BPF + 1);

    // fifo_level + BURST <= FIFO_DEPTH, rearranged to avoid widening.
    localparam logic [LW-1:0]    C_SPACE_MAX = LW'(FIFO_DEPTH - BURST);
    localparam logic [LW-1:0]    C_LOW_WATER = LW'(LOW_WATER);
    localparam logic [CW-1:0]    C_BPF_W     = CW'(C_BPF);
    localparam logic [ADDRW-1:0] C_BASE      = ADDRW'(FB_BASE);
    localparam logic [ADDRW-1:0] C_BURST_A   = ADDRW'(BURST);

    scanout_state_t   r_state;
    logic [ADDRW-1:0] r_disp_addr;
    logic [CW-1:0]    r_burst_cnt;
    logic             r_frame_pend;

    logic       w_disp_pend;
    logic       w_urgent;
    logic       w_accept;
    logic       w_accept_disp;
    logic       w_accept_gpu;
    logic       w_grant_valid;
    requester_t w_grant_sel;

    assign w_disp_pend   = enable && (r_burst_cnt < C_BPF_W) &&
                           (fifo_level <= C_SPACE_MAX) && !r_frame_pend;
    assign w_urgent      = fifo_level < C_LOW_WATER;
    assign w_accept      = mem_req && mem_ready;
    assign w_accept_disp = w_accept && (r_state == ST_ISSUE_D);
    assign w_accept_gpu  = w_accept && (r_state == ST_ISSUE_G);

    scanout_rr_arb2 u_arb (
        .clk_pix     (clk_pix),
        .rst_n       (rst_n),
        .disp_pend   (w_disp_pend),
        .gpu_req     (gpu_req),
        .urgent      (w_urgent),
        .accept_disp (w_accept_disp),
        .accept_gpu  (w_accept_gpu),
        .grant_valid (w_grant_valid),
        .grant_sel   (w_grant_sel)
    );

    always_ff @(posedge clk_pix or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= ST_IDLE;
            r_disp_addr  <= C_BASE;
            r_burst_cnt  <= '0;
            r_frame_pend <= 1'b0;
            fifo_flush   <= 1'b0;
            underflow    <= 1'b0;
            gpu_gnt      <= 1'b0;
            gpu_done     <= 1'b0;
            mem_req      <= 1'b0;
            mem_we       <= 1'b0;
            mem_burst    <= 1'b0;
            mem_addr     <= '0;
        end else begin
            fifo_flush <= 1'b0;
            gpu_gnt    <= 1'b0;
            gpu_done   <= 1'b0;

            if (frame) begin
                r_frame_pend <= 1'b1;
            end

            case (r_state)
                ST_IDLE: begin
                    if (r_frame_pend) begin
                        // Rewind only here so an in-flight burst lands first
                        // and is then discarded by the flush.
                        fifo_flush   <= 1'b1;
                        r_disp_addr  <= C_BASE;
                        r_burst_cnt  <= '0;
                        r_frame_pend <= frame;
                        underflow    <= 1'b0;
                    end else if (w_grant_valid) begin
                        mem_req <= 1'b1;
                        if (w_grant_sel == REQ_DISP) begin
                            r_state   <= ST_ISSUE_D;
                            mem_burst <= 1'b1;
                            mem_we    <= 1'b0;
                            mem_addr  <= r_disp_addr;
                        end else begin
                            r_state   <= ST_ISSUE_G;
                            mem_burst <= 1'b0;
                            mem_we    <= gpu_we;
                            mem_addr  <= gpu_addr;
                        end
                    end
                end
                ST_ISSUE_D: begin
                    if (w_accept) begin
                        mem_req     <= 1'b0;
                        r_disp_addr <= r_disp_addr + C_BURST_A;
                        r_burst_cnt <= r_burst_cnt + 1'b1;
                        r_state     <= ST_WAIT_D;
                    end
                end
                ST_ISSUE_G: begin
                    if (w_accept) begin
                        mem_req <= 1'b0;
                        gpu_gnt <= 1'b1;
                        r_state <= ST_WAIT_G;
                    end
                end
                ST_WAIT_D: begin
                    if (mem_done) begin
                        r_state <= ST_IDLE;
                    end
                end
                ST_WAIT_G: begin
                    if (mem_done) begin
                        gpu_done <= 1'b1;
                        r_state  <= ST_IDLE;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase

            // Placed last so a coincident set overrides the frame clear.
            if (de && (fifo_level == '0)) begin
                underflow <= 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_framebuffer_scanout_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_framebuffer_scanout_arbiter
// Description : Directed self-checking bench for the scanout arbiter. Uses a
//               reduced 32x4 frame (8 bursts) so end-of-frame is reachable
//               quickly; burst size and FIFO geometry are the defaults.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_framebuffer_scanout_arbiter;

    localparam int ADDRW = 24;

    logic             clk_pix = 1'b0;
    logic             rst_n;
    logic             enable;
    logic             frame;
    logic             de;
    logic [6:0]       fifo_level;
    logic             fifo_flush;
    logic             underflow;
    logic             gpu_req;
    logic             gpu_we;
    logic [ADDRW-1:0] gpu_addr;
    logic             gpu_gnt;
    logic             gpu_done;
    logic             mem_req;
    logic             mem_we;
    logic             mem_burst;
    logic [ADDRW-1:0] mem_addr;
    logic             mem_ready;
    logic             mem_done;

    int total = 0;
    int bad   = 0;

    framebuffer_scanout_arbiter #(
        .H_RES(32), .V_RES(4), .ADDRW(ADDRW), .BURST(16),
        .FB_BASE(0), .FIFO_DEPTH(64), .LOW_WATER(16)
    ) dut (
        .clk_pix    (clk_pix),
        .rst_n      (rst_n),
        .enable     (enable),
        .frame      (frame),
        .de         (de),
        .fifo_level (fifo_level),
        .fifo_flush (fifo_flush),
        .underflow  (underflow),
        .gpu_req    (gpu_req),
        .gpu_we     (gpu_we),
        .gpu_addr   (gpu_addr),
        .gpu_gnt    (gpu_gnt),
        .gpu_done   (gpu_done),
        .mem_req    (mem_req),
        .mem_we     (mem_we),
        .mem_burst  (mem_burst),
        .mem_addr   (mem_addr),
        .mem_ready  (mem_ready),
        .mem_done   (mem_done)
    );

    always #5 clk_pix = ~clk_pix;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_pix);
        #1;
    endtask

    // Accept the pending request, then complete it on the next cycle.
    task automatic finish_xfer();
        mem_ready = 1'b1;
        tick();
        mem_ready = 1'b0;
        mem_done  = 1'b1;
        tick();
        mem_done  = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; enable = 1'b0; frame = 1'b0; de = 1'b0;
        fifo_level = 7'd32; gpu_req = 1'b0; gpu_we = 1'b0; gpu_addr = '0;
        mem_ready = 1'b0; mem_done = 1'b0;
        repeat (2) tick();
        check("rst_mem_req",    {31'b0, mem_req},    32'd0);
        check("rst_fifo_flush", {31'b0, fifo_flush}, 32'd0);
        check("rst_underflow",  {31'b0, underflow},  32'd0);
        check("rst_gpu_gnt",    {31'b0, gpu_gnt},    32'd0);

        // First burst after reset starts at the framebuffer base.
        rst_n = 1'b1; enable = 1'b1; fifo_level = 7'd0;
        tick();
        check("first_req",   {31'b0, mem_req},   32'd1);
        check("first_burst", {31'b0, mem_burst}, 32'd1);
        check("first_addr",  32'(mem_addr),      32'd0);
        de = 1'b1; tick(); de = 1'b0;
        check("underflow_set", {31'b0, underflow}, 32'd1);

        // Asynchronous reset mid-cycle while a request is pending.
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_req",       {31'b0, mem_req},   32'd0);
        check("async_rst_underflow", {31'b0, underflow}, 32'd0);
        tick();
        rst_n = 1'b1;
        tick();
        check("post_rst_addr", 32'(mem_addr), 32'd0);

        // Frame arriving with a burst in flight: flush only after completion.
        frame = 1'b1; tick(); frame = 1'b0;
        finish_xfer();
        check("no_flush_inflight", {31'b0, fifo_flush}, 32'd0);
        tick();
        check("flush_pulse",    {31'b0, fifo_flush}, 32'd1);
        check("flush_no_req",   {31'b0, mem_req},    32'd0);
        tick();
        check("flush_one_cycle", {31'b0, fifo_flush}, 32'd0);
        check("rewind_req",      {31'b0, mem_req},    32'd1);
        check("rewind_addr",     32'(mem_addr),       32'd0);
        check("rewind_we",       {31'b0, mem_we},     32'd0);
        finish_xfer();
        tick();
        check("second_addr", 32'(mem_addr), 32'd16);
        finish_xfer();

        // FIFO space threshold: 49+16 > 64 blocks, 48+16 == 64 allows.
        fifo_level = 7'd49;
        tick();
        check("lvl49_noreq", {31'b0, mem_req}, 32'd0);
        fifo_level = 7'd48;
        tick();
        check("lvl48_req",  {31'b0, mem_req}, 32'd1);
        check("lvl48_addr", 32'(mem_addr),    32'd32);

        // Round-robin contention at a comfortable FIFO level.
        fifo_level = 7'd32; gpu_req = 1'b1; gpu_we = 1'b1; gpu_addr = 24'h123456;
        finish_xfer();
        tick();
        check("rr_gpu_burst", {31'b0, mem_burst}, 32'd0);
        check("rr_gpu_we",    {31'b0, mem_we},    32'd1);
        check("rr_gpu_addr",  32'(mem_addr),      32'h123456);
        mem_ready = 1'b1; tick(); mem_ready = 1'b0;
        check("gnt_pulse", {31'b0, gpu_gnt}, 32'd1);
        mem_done = 1'b1; tick(); mem_done = 1'b0;
        check("gnt_single",   {31'b0, gpu_gnt},  32'd0);
        check("gpu_done_set", {31'b0, gpu_done}, 32'd1);
        tick();
        check("gpu_done_clr", {31'b0, gpu_done},  32'd0);
        check("rr_disp_next", {31'b0, mem_burst}, 32'd1);
        check("rr_disp_addr", 32'(mem_addr),      32'd48);
        finish_xfer();
        tick();
        check("rr_gpu_again", {31'b0, mem_burst}, 32'd0);

        // Urgent level: display wins twice in a row while GPU waits.
        fifo_level = 7'd8;
        finish_xfer();
        tick();
        check("urg_disp1", 32'(mem_addr), 32'd64);
        finish_xfer();
        tick();
        check("urg_disp2_burst", {31'b0, mem_burst}, 32'd1);
        check("urg_disp2_addr",  32'(mem_addr),      32'd80);
        check("urg_no_gnt",      {31'b0, gpu_gnt},   32'd0);
        finish_xfer();
        fifo_level = 7'd32;
        tick();
        check("urg_gpu_after", {31'b0, mem_burst}, 32'd0);
        finish_xfer();
        gpu_req = 1'b0;

        // Last two bursts of the frame, then display stops.
        tick();
        check("burst7_addr", 32'(mem_addr), 32'd96);
        finish_xfer();
        tick();
        check("burst8_addr", 32'(mem_addr), 32'd112);
        finish_xfer();
        tick();
        check("frame_end_noreq", {31'b0, mem_req}, 32'd0);
        gpu_req = 1'b1; gpu_we = 1'b0; gpu_addr = 24'h000055;
        tick();
        check("frame_end_gpu_req",  {31'b0, mem_req},   32'd1);
        check("frame_end_gpu_addr", 32'(mem_addr),      32'h55);
        check("frame_end_gpu_we",   {31'b0, mem_we},    32'd0);
        finish_xfer();
        gpu_req = 1'b0;

        // Underflow stays set until the next frame is applied.
        de = 1'b1; fifo_level = 7'd0;
        tick();
        de = 1'b0; fifo_level = 7'd32;
        tick(); tick();
        check("underflow_sticky", {31'b0, underflow}, 32'd1);
        frame = 1'b1; tick(); frame = 1'b0;
        check("underflow_pending", {31'b0, underflow}, 32'd1);
        tick();
        check("frame_flush",     {31'b0, fifo_flush}, 32'd1);
        check("underflow_clear", {31'b0, underflow},  32'd0);
        tick();
        check("new_frame_addr", 32'(mem_addr), 32'd0);

        // Frame pulse during WAIT_D.
        mem_ready = 1'b1; tick(); mem_ready = 1'b0;
        frame = 1'b1; tick(); frame = 1'b0;
        check("waitd_no_flush", {31'b0, fifo_flush}, 32'd0);
        mem_done = 1'b1; tick(); mem_done = 1'b0;
        check("waitd_done_no_flush", {31'b0, fifo_flush}, 32'd0);
        tick();
        check("waitd_flush", {31'b0, fifo_flush}, 32'd1);
        tick();
        check("waitd_rewind_req",  {31'b0, mem_req}, 32'd1);
        check("waitd_rewind_addr", 32'(mem_addr),    32'd0);

        // Disabling blocks new display bursts once the current one ends.
        enable = 1'b0;
        finish_xfer();
        tick();
        check("disabled_noreq", {31'b0, mem_req}, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got=timeout expected=finish");
        $fatal(1);
    end

endmodule
`default_nettype wire
